// File: rtl/hpdcache_flush_sched.sv
// hpdcache_flush_sched: flush-all sequencer that scans every directory set and hands
// each valid dirty line to the flush controller, clearing its dirty bit on acceptance.
module hpdcache_flush_sched #(
  parameter int unsigned Sets     = 64,
  parameter int unsigned Ways     = 4,
  parameter int unsigned TagWidth = 20
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  output logic                               start_ready_o,
  output logic                               done_o,
  output logic                               busy_o,
  output logic                               dir_req_o,
  output logic [$clog2(Sets)-1:0]            dir_req_set_o,
  input  logic                               dir_gnt_i,
  input  logic [Ways-1:0]                    dir_valid_i,
  input  logic [Ways-1:0]                    dir_dirty_i,
  input  logic [Ways*TagWidth-1:0]           dir_tag_i,
  output logic                               dir_clr_o,
  output logic [$clog2(Sets)-1:0]            dir_clr_set_o,
  output logic [Ways-1:0]                    dir_clr_way_o,
  output logic                               flush_alloc_o,
  input  logic                               flush_alloc_ready_i,
  output logic [TagWidth+$clog2(Sets)-1:0]   flush_alloc_nline_o,
  output logic [Ways-1:0]                    flush_alloc_way_o,
  input  logic                               flush_empty_i
);
  localparam int unsigned SetW = $clog2(Sets);
  typedef enum logic [2:0] {IDLE, READ, WAIT, FLUSH, DRAIN} state_e;
  state_e                   state_q;
  logic [SetW-1:0]          set_q;
  logic [Ways-1:0]          mask_q;
  logic [Ways*TagWidth-1:0] tags_q;
  logic [Ways-1:0]          sel;
  logic [Ways-1:0]          dir_mask;
  logic [TagWidth-1:0]      sel_tag;
  logic                     last;
  state_e                   adv_state;
  logic [SetW-1:0]          adv_set;
  // lowest pending way wins, so ways are flushed in ascending order
  assign sel       = mask_q & (~mask_q + 1'b1);
  assign dir_mask  = dir_valid_i & dir_dirty_i;
  assign last      = &set_q;
  assign adv_state = last ? DRAIN : READ;
  assign adv_set   = last ? set_q : set_q + 1'b1;
  always_comb begin
    sel_tag = '0;
    for (int w = 0; w < Ways; w++) sel_tag |= sel[w] ? tags_q[w*TagWidth +: TagWidth] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      set_q   <= '0;
      mask_q  <= '0;
      tags_q  <= '0;
    end else case (state_q)
      IDLE: if (start_i) begin
        set_q   <= '0;
        state_q <= READ;
      end
      READ: if (dir_gnt_i) state_q <= WAIT;
      WAIT: begin
        mask_q <= dir_mask;
        tags_q <= dir_tag_i;
        if (|dir_mask) state_q <= FLUSH;
        else begin
          state_q <= adv_state;
          set_q   <= adv_set;
        end
      end
      FLUSH: if (flush_alloc_ready_i) begin
        mask_q <= mask_q & ~sel;
        if (mask_q == sel) begin
          state_q <= adv_state;
          set_q   <= adv_set;
        end
      end
      DRAIN: if (flush_empty_i) state_q <= IDLE;
      default: state_q <= IDLE;
    endcase
  assign start_ready_o       = state_q == IDLE;
  assign busy_o              = state_q != IDLE;
  assign done_o              = state_q == DRAIN && flush_empty_i;
  assign dir_req_o           = state_q == READ;
  assign dir_req_set_o       = set_q;
  assign flush_alloc_o       = state_q == FLUSH;
  assign flush_alloc_nline_o = {sel_tag, set_q};
  assign flush_alloc_way_o   = sel;
  assign dir_clr_o           = flush_alloc_o && flush_alloc_ready_i;
  assign dir_clr_set_o       = set_q;
  assign dir_clr_way_o       = sel;
endmodule

// File: tb/tb_hpdcache_flush_sched.sv
// tb_hpdcache_flush_sched: randomized scoreboard bench; expectations are derived from a
// directory model at each accepted start, checked by an independent negedge monitor.
module tb_hpdcache_flush_sched;
  localparam int S = 4, W = 4, T = 8, SW = 2, NW = T + SW;
  logic clk_i = 0, rst_ni = 0, start_i = 0;
  logic dir_gnt_i = 0, flush_alloc_ready_i = 0, flush_empty_i = 0;
  logic start_ready_o, done_o, busy_o, dir_req_o, dir_clr_o, flush_alloc_o;
  logic [SW-1:0] dir_req_set_o, dir_clr_set_o;
  logic [W-1:0] dir_valid_i, dir_dirty_i, dir_clr_way_o, flush_alloc_way_o;
  logic [W*T-1:0] dir_tag_i;
  logic [NW-1:0] flush_alloc_nline_o;
  logic [W-1:0] mv[S], md[S];
  logic [T-1:0] mt[S][W];
  logic [SW-1:0] rd_set = '0;
  typedef struct packed {logic [NW-1:0] nline; logic [W-1:0] way;} alloc_t;
  typedef struct packed {logic [SW-1:0] set; int off;} rd_t;
  alloc_t exp_a[$];
  rd_t exp_r[$];
  alloc_t a;
  rd_t r;
  int vec = 0, err = 0, cyc = 0, acc_cyc = 0, exp_lat = 0, exp_done = 0, done_cnt = 0, alloc_cnt = 0;
  bit fast = 0, rnd = 0, mid = 0, prev_a = 0, prev_r = 0;
  logic [NW-1:0] pa_nline;
  logic [W-1:0] pa_way;
  logic [SW-1:0] pr_set;

  hpdcache_flush_sched #(.Sets(S), .Ways(W), .TagWidth(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .start_ready_o(start_ready_o),
    .done_o(done_o), .busy_o(busy_o), .dir_req_o(dir_req_o), .dir_req_set_o(dir_req_set_o),
    .dir_gnt_i(dir_gnt_i), .dir_valid_i(dir_valid_i), .dir_dirty_i(dir_dirty_i),
    .dir_tag_i(dir_tag_i), .dir_clr_o(dir_clr_o), .dir_clr_set_o(dir_clr_set_o),
    .dir_clr_way_o(dir_clr_way_o), .flush_alloc_o(flush_alloc_o),
    .flush_alloc_ready_i(flush_alloc_ready_i), .flush_alloc_nline_o(flush_alloc_nline_o),
    .flush_alloc_way_o(flush_alloc_way_o), .flush_empty_i(flush_empty_i));

  always #5 clk_i = ~clk_i;

  always_comb begin
    dir_valid_i = mv[rd_set];
    dir_dirty_i = md[rd_set];
    for (int w = 0; w < W; w++) dir_tag_i[w*T +: T] = mt[rd_set][w];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor + scoreboard
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      prev_a = 0;
      prev_r = 0;
    end else begin
      chk("busy_vs_ready", busy_o, !start_ready_o);
      chk("clr_iff_accept", dir_clr_o, flush_alloc_o & flush_alloc_ready_i);
      if (prev_a) chk("alloc_hold", {flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o}, {1'b1, pa_nline, pa_way});
      if (prev_r) chk("req_hold", {dir_req_o, dir_req_set_o}, {1'b1, pr_set});
      prev_a = flush_alloc_o && !flush_alloc_ready_i;
      pa_nline = flush_alloc_nline_o;
      pa_way = flush_alloc_way_o;
      prev_r = dir_req_o && !dir_gnt_i;
      pr_set = dir_req_set_o;
      if (start_i && start_ready_o) begin
        int off;
        exp_a.delete();
        exp_r.delete();
        off = 1;
        for (int s = 0; s < S; s++) begin
          int k;
          k = 0;
          exp_r.push_back('{set: SW'(s), off: off});
          for (int w = 0; w < W; w++)
            if (mv[s][w] && md[s][w]) begin
              logic [W-1:0] oh;
              oh = '0;
              oh[w] = 1'b1;
              exp_a.push_back('{nline: {mt[s][w], SW'(s)}, way: oh});
              k++;
            end
          off += 2 + k;
        end
        exp_lat = off;
        acc_cyc = cyc;
        exp_done = 1;
      end
      if (dir_req_o && dir_gnt_i) begin
        chk("read_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) begin
          r = exp_r.pop_front();
          chk("read_set", dir_req_set_o, r.set);
          if (fast) chk("read_cycle", cyc - acc_cyc, r.off);
        end
        rd_set = dir_req_set_o;
      end
      if (flush_alloc_o && flush_alloc_ready_i) begin
        alloc_cnt++;
        chk("alloc_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          a = exp_a.pop_front();
          chk("alloc_nline", flush_alloc_nline_o, a.nline);
          chk("alloc_way", flush_alloc_way_o, a.way);
          chk("clr_set", dir_clr_set_o, a.nline[SW-1:0]);
          chk("clr_way", dir_clr_way_o, a.way);
        end
        md[dir_clr_set_o] = md[dir_clr_set_o] & ~dir_clr_way_o;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_expected", exp_done, 1);
        chk("done_needs_empty", flush_empty_i, 1);
        chk("done_allocs_left", exp_a.size(), 0);
        chk("done_reads_left", exp_r.size(), 0);
        if (fast) chk("done_latency", cyc - acc_cyc, exp_lat);
        exp_done = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rnd) begin
      dir_gnt_i = $urandom_range(0, 3) != 0;
      flush_alloc_ready_i = $urandom_range(0, 3) != 0;
      flush_empty_i = $urandom_range(0, 2) != 0;
    end
  endtask

  task automatic start_run();
    start_i = 1;
    step();
    start_i = 0;
  endtask

  task automatic wait_done(input int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      start_i = mid && done_cnt == base && $urandom_range(0, 5) == 0;
      n++;
    end
    start_i = 0;
    chk("run_one_done", done_cnt - base, 1);
  endtask

  task automatic wait_alloc();
    int n;
    n = 0;
    while (!flush_alloc_o && n < 50) begin
      step();
      n++;
    end
    chk("alloc_reached", flush_alloc_o, 1);
  endtask

  task automatic check_clean();
    int c;
    c = 0;
    for (int s = 0; s < S; s++) for (int w = 0; w < W; w++) c += int'(mv[s][w] & md[s][w]);
    chk("all_flushed", c, 0);
  endtask

  task automatic clear_dir();
    for (int s = 0; s < S; s++) begin
      mv[s] = '0;
      md[s] = '0;
      for (int w = 0; w < W; w++) mt[s][w] = '0;
    end
  endtask

  task automatic rand_dir();
    for (int s = 0; s < S; s++) begin
      mv[s] = W'($urandom);
      md[s] = W'($urandom);
      for (int w = 0; w < W; w++) mt[s][w] = T'($urandom);
    end
  endtask

  task automatic all_high();
    rnd = 0;
    dir_gnt_i = 1;
    flush_alloc_ready_i = 1;
    flush_empty_i = 1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_start_ready"}, start_ready_o, 1);
    chk({tag, "_dir_req"}, dir_req_o, 0);
    chk({tag, "_dir_clr"}, dir_clr_o, 0);
    chk({tag, "_alloc"}, flush_alloc_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    clear_dir();
    @(negedge clk_i);
    chk_idle("in_reset");
    @(posedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    chk_idle("after_reset");
    // all clean, everything ready: reads at 1,3,5,7 and done at 9
    all_high();
    fast = 1;
    step();
    start_run();
    wait_done(100);
    // dirty lines in set 2, a dirty-but-invalid way in set 1
    mv[2] = 4'b1111; md[2] = 4'b1010;
    mt[2][0] = 8'h11; mt[2][1] = 8'h22; mt[2][2] = 8'h33; mt[2][3] = 8'h44;
    mv[1] = 4'b0000; md[1] = 4'b0001;
    start_run();
    wait_done(100);
    check_clean();
    fast = 0;
    // allocation stalled for 5 cycles
    mv[0] = 4'b0001; md[0] = 4'b0001; mt[0][0] = 8'h5a;
    mv[3] = 4'b0101; md[3] = 4'b0111; mt[3][0] = 8'hc3; mt[3][2] = 8'h3c;
    flush_alloc_ready_i = 0;
    start_run();
    wait_alloc();
    repeat (5) step();
    flush_alloc_ready_i = 1;
    wait_done(100);
    check_clean();
    // grant withheld on set 0, then drain held off for 10 cycles
    mv[1] = 4'b1000; md[1] = 4'b1000; mt[1][3] = 8'h77;
    dir_gnt_i = 0;
    flush_empty_i = 0;
    base = done_cnt;
    start_run();
    repeat (3) step();
    dir_gnt_i = 1;
    begin
      int n;
      n = 0;
      while ((exp_r.size() != 0 || exp_a.size() != 0) && n < 100) begin
        step();
        n++;
      end
      chk("scan_finished", exp_r.size() + exp_a.size(), 0);
    end
    repeat (10) step();
    chk("no_done_while_not_empty", done_cnt - base, 0);
    flush_empty_i = 1;
    @(negedge clk_i);
    chk("done_on_empty_rise", done_o, 1);
    step();
    chk("drain_one_done", done_cnt - base, 1);
    check_clean();
    // reset in FLUSH after one line has been accepted
    rand_dir();
    mv[0] = 4'b0111; md[0] = 4'b0111;
    base = alloc_cnt;
    start_run();
    wait_alloc();
    while (alloc_cnt == base && flush_alloc_o) step();
    flush_alloc_ready_i = 0;
    wait_alloc();
    base = done_cnt;
    rst_ni = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_alloc", flush_alloc_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_first_line_stays_clean", md[0][0], 0);
    exp_a.delete();
    exp_r.delete();
    exp_done = 0;
    step();
    rst_ni = 1;
    all_high();
    step();
    chk("rst_no_done", done_cnt - base, 0);
    fast = 1;
    start_run();
    wait_done(200);
    check_clean();
    fast = 0;
    // randomized runs, with stray start pulses mid-scan
    mid = 1;
    for (int i = 0; i < 8; i++) begin
      rand_dir();
      rnd = 1;
      start_run();
      wait_done(2000);
      check_clean();
    end
    mid = 0;
    rnd = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
